// File: rtl/mod_switches_db_if.sv
// Instruction/data bus port of the debounced switch peripheral.
// The slave drives iout/dout and tri-states them when its enable is low.
interface mod_switches_db_if;
    logic        ie;
    logic        de;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic        drw;
    logic [31:0] din;
    logic [31:0] iout;
    logic [31:0] dout;

    modport master (output ie, de, iaddr, daddr, drw, din, input iout, dout);
    modport slave  (input ie, de, iaddr, daddr, drw, din, output iout, dout);
endinterface

// File: rtl/mod_switches_db.sv
// Debounced switch/button peripheral: STATE (RO), CAPTURE (W1C), MASK (RW) and a level irq.
// Define SWITCHES_FALLING_EDGE_EN to turn register 3 into a W1C falling-edge capture.
module mod_switches_db #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               rst,
    mod_switches_db_if.slave   bus,
    input  logic [WIDTH-1:0]   switches,
    output logic               irq
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       A_STATE  = 2'd0;
    localparam logic [1:0]       A_CAP    = 2'd1;
    localparam logic [1:0]       A_MASK   = 2'd2;
    localparam logic [1:0]       A_FALL   = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] wdata;
    logic [1:0]       addr;
    logic             wr_en;
    logic [31:0]      rdata;
    logic             unused_bus;

    assign addr       = bus.daddr[3:2];
    assign wr_en      = bus.de && bus.drw;
    assign wdata      = bus.din[WIDTH-1:0];
    assign sync_last  = sync_q[SYNC_STAGES-1];
    assign unused_bus = ^{bus.iaddr, bus.daddr, bus.din};

    // Per-channel debounce: commit only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        state_d = state_q;
        rise    = '0;
        fall    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_last[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                state_d[i] = sync_last[i];
                cnt_d[i]   = '0;
                rise[i]    = sync_last[i];
                fall[i]    = ~sync_last[i];
            end else begin
                cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
            end
        end
    end

    // A commit on the same edge as a W1C of that bit leaves the bit set
    assign cap_d = (cap_q & ~((wr_en && addr == A_CAP) ? wdata : '0)) | rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
            state_q <= '0;
            cap_q   <= '0;
            mask_q  <= '0;
        end else begin
            sync_q[0] <= switches;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
            state_q <= state_d;
            cap_q   <= cap_d;
            if (wr_en && addr == A_MASK) mask_q <= wdata;
        end
    end

`ifdef SWITCHES_FALLING_EDGE_EN
    logic [WIDTH-1:0] fall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fall_q <= '0;
        end else begin
            fall_q <= (fall_q & ~((wr_en && addr == A_FALL) ? wdata : '0)) | fall;
        end
    end

    assign irq = |((cap_q | fall_q) & mask_q);
`else
    logic [WIDTH-1:0] fall_q;
    logic             unused_fall;

    assign fall_q      = '0;
    assign unused_fall = ^fall;
    assign irq         = |(cap_q & mask_q);
`endif

    // Combinational read mux; register bits above WIDTH read as zero
    always_comb begin
        rdata = '0;
        case (addr)
            A_STATE: rdata = 32'(state_q);
            A_CAP:   rdata = 32'(cap_q);
            A_MASK:  rdata = 32'(mask_q);
            A_FALL:  rdata = 32'(fall_q);
            default: rdata = '0;
        endcase
    end

    assign bus.dout = bus.de ? rdata : 'z;
    assign bus.iout = bus.ie ? 32'h0 : 'z;

endmodule

// File: tb/tb_mod_switches_db.sv
// Scoreboard bench for mod_switches_db (WIDTH=8, DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
// The driver pushes hand-computed expectations; a negedge monitor pops and compares them.
module tb_mod_switches_db;

    localparam logic [1:0] R_STATE = 2'd0;
    localparam logic [1:0] R_CAP   = 2'd1;
    localparam logic [1:0] R_MASK  = 2'd2;
    localparam logic [1:0] R_RSVD  = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] switches = 8'h00;
    logic       irq;

    mod_switches_db_if bus();

    mod_switches_db #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .switches (switches),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;   // 0 dout, 1 iout, 2 irq
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] got;
            e = q.pop_front();
            case (e.kind)
                0:       got = bus.dout;
                1:       got = bus.iout;
                default: got = {31'h0, irq};
            endcase
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h at %0t", e.name, got, e.val, $time);
            end
        end
    end

    function automatic void push(string name, int kind, logic [31:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endfunction

    task automatic next_slot();
        @(posedge clk);
        #1;
    endtask

    // One-cycle read; irq_exp < 0 skips the irq comparison
    task automatic rd(input logic [1:0] a, input logic [31:0] v, input string name, input int irq_exp);
        bus.de    = 1'b1;
        bus.drw   = 1'b0;
        bus.daddr = {28'h0, a, 2'b00};
        push(name, 0, v);
        if (irq_exp >= 0) push({name, "_irq"}, 2, 32'(irq_exp));
        @(negedge clk);
        #1;
        bus.de = 1'b0;
        next_slot();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.de    = 1'b1;
        bus.drw   = 1'b1;
        bus.daddr = {28'h0, a, 2'b00};
        bus.din   = d;
        next_slot();
        bus.de  = 1'b0;
        bus.drw = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) next_slot();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] fall_exp;
        bus.ie = 1'b0; bus.de = 1'b0; bus.drw = 1'b0;
        bus.iaddr = 32'h0; bus.daddr = 32'h0; bus.din = 32'h0;
        next_slot();

        // Reset held: switch activity must not reach any register
        switches = 8'hFF;
        idle(3);
        n_checks++;
        if (bus.dout !== 32'hzzzz_zzzz) begin
            n_fail++;
            $display("FAIL rst_dout_hiz: got %h at %0t", bus.dout, $time);
        end
        n_checks++;
        if (bus.iout !== 32'hzzzz_zzzz) begin
            n_fail++;
            $display("FAIL rst_iout_hiz: got %h at %0t", bus.iout, $time);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_irq: got %b at %0t", irq, $time);
        end
        switches = 8'hA5;
        rd(R_STATE, 32'h0, "rst_state", 0);
        switches = 8'h3C;
        rd(R_CAP, 32'h0, "rst_cap", 0);
        rd(R_MASK, 32'h0, "rst_mask", 0);
        bus.ie = 1'b1;
        push("iout_zero", 1, 32'h0);
        idle(1);
        bus.ie = 1'b0;
        switches = 8'h00;
        rst = 1'b1;
        idle(3);

        // Rising 0x05: STATE and CAPTURE commit on the 6th edge
        wr(R_MASK, 32'h5);
        switches = 8'h05;
        for (int k = 0; k < 8; k++)
            rd(R_STATE, (k >= 6) ? 32'h5 : 32'h0, $sformatf("lat_state_%0d", k), (k >= 6) ? 1 : 0);
        rd(R_CAP, 32'h5, "lat_cap", 1);

        // Glitch filtering: 3-clock pulse ignored, 4-clock pulse commits then reverts
        switches = 8'h00;
        idle(8);
        rd(R_STATE, 32'h0, "fall_state", -1);
        wr(R_CAP, 32'hFF);
        rd(R_CAP, 32'h0, "cap_cleared", 0);
        for (int k = 0; k < 12; k++) begin
            switches = (k < 3) ? 8'h01 : 8'h00;
            rd(R_STATE, 32'h0, $sformatf("glitch3_%0d", k), -1);
        end
        rd(R_CAP, 32'h0, "glitch3_cap", 0);
        for (int k = 0; k < 12; k++) begin
            switches = (k < 4) ? 8'h01 : 8'h00;
            rd(R_STATE, (k >= 6 && k <= 9) ? 32'h1 : 32'h0, $sformatf("pulse4_%0d", k), -1);
        end
        rd(R_CAP, 32'h1, "pulse4_cap", 1);

        // Masking and W1C
        wr(R_CAP, 32'hFF);
        switches = 8'h05;
        idle(8);
        wr(R_MASK, 32'h4);
        rd(R_CAP, 32'h5, "irq_cap5", 1);
        wr(R_CAP, 32'h4);
        rd(R_CAP, 32'h1, "w1c_bit2", 0);
        wr(R_MASK, 32'h1);
        rd(R_CAP, 32'h1, "mask_change", 1);
        rd(R_MASK, 32'h1, "mask_rd", 1);
        wr(R_STATE, 32'h0);
        rd(R_STATE, 32'h5, "state_ro", -1);
        wr(R_RSVD, 32'hFF);
        rd(R_RSVD, 32'h0, "reg3_after_clear", -1);

        // W1C of bit 1 on the edge bit 1 commits: set wins
        switches = 8'h07;
        for (int k = 0; k < 5; k++)
            rd(R_STATE, 32'h5, $sformatf("race_state_%0d", k), -1);
        wr(R_CAP, 32'h2);
        rd(R_CAP, 32'h3, "set_wins", 1);
        rd(R_STATE, 32'h7, "race_state_done", -1);
        wr(R_CAP, 32'h2);
        rd(R_CAP, 32'h1, "w1c_bit1", 1);

        // Reset mid-debounce (bit 3 counter at 2) restarts the full latency
        switches = 8'h0F;
        for (int k = 0; k < 4; k++)
            rd(R_STATE, 32'h7, $sformatf("pre_rst_%0d", k), -1);
        rst = 1'b0;
        rd(R_STATE, 32'h0, "mid_rst_state", 0);
        rst = 1'b1;
        for (int k = 0; k < 8; k++)
            rd(R_STATE, (k >= 6) ? 32'hF : 32'h0, $sformatf("post_rst_%0d", k), 0);
        rd(R_CAP, 32'hF, "post_rst_cap", 0);
        rd(R_MASK, 32'h0, "post_rst_mask", 0);

        // Falling commit on bit 0: recorded only with the falling-edge option
        switches = 8'h0E;
        idle(8);
        rd(R_STATE, 32'hE, "fall_state_e", -1);
`ifdef SWITCHES_FALLING_EDGE_EN
        fall_exp = 32'h1;
`else
        fall_exp = 32'h0;
`endif
        rd(R_RSVD, fall_exp, "reg3_fall", -1);

        idle(2);
        n_checks++;
        if (bus.dout !== 32'hzzzz_zzzz) begin
            n_fail++;
            $display("FAIL end_dout_hiz: got %h at %0t", bus.dout, $time);
        end
        n_checks++;
        if (bus.iout !== 32'hzzzz_zzzz) begin
            n_fail++;
            $display("FAIL end_iout_hiz: got %h at %0t", bus.iout, $time);
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL end_irq_masked: got %b at %0t", irq, $time);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
